switch_port_arbiter: RTL and testbench

Clocked output-port arbiter for the 5-port bundled-data switch. Shares one downstream channel between PORTS upstream channels. Each channel uses a four-phase req/ack handshake with bundled data. Grants rotate round-robin at packet granularity: a winner stays locked until a flit with its tail bit set has fully handshaken. It sits between the input buffers and one switch output, bridging the asynchronous handshake wires into a single clock domain through input synchronizers.

---
 rtl/switch_port_arbiter.sv | 136 +++++++++++++
 tb/tb_switch_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_arbiter.sv
// Round-robin output-port arbiter: shares one downstream four-phase channel among PORTS upstream channels, locked per packet.
// Latency: SYNC_STAGES edges to see a request, +1 edge to grant, +1 edge to drive req_dw_o (4 edges from first sample at SYNC_STAGES=2).
// Backpressure: the downstream ack gates every flit; upstream ack is withheld until downstream acks, and the grant is held until the tail flit returns to zero.
module switch_port_arbiter #(
  parameter int WIDTH       = 128,
  parameter int PORTS       = 5,
  parameter int TAIL_BIT    = WIDTH - 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PORTS-1:0]       req_up_i,
  input  logic [PORTS*WIDTH-1:0] data_up_i,
  output logic [PORTS-1:0]       ack_up_o,
  output logic                   req_dw_o,
  output logic [WIDTH-1:0]       data_dw_o,
  input  logic                   ack_dw_i,
  output logic [PORTS-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOCKED = 3'd1,
    LOAD   = 3'd2,
    REQ    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                          state;
  logic [SYNC_STAGES-1:0][PORTS-1:0] req_sync;
  logic [SYNC_STAGES-1:0]          ack_sync;
  logic [PORTS-1:0]                req_s;
  logic                            ack_s;
  logic [PW-1:0]                   ptr;
  logic [PW-1:0]                   gidx;
  logic [PW-1:0]                   win_idx;
  logic                            win_vld;
  logic [PW:0]                     cand;
  logic                            tail_r;
  logic [WIDTH-1:0]                slice [PORTS];

  // Break out each port's bundled data lane.
  for (genvar p = 0; p < PORTS; p++) begin : g_slice
    assign slice[p] = data_up_i[p*WIDTH +: WIDTH];
  end

  // Bring the asynchronous handshake wires into the clk domain; index 0 is the first stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_up_i};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_dw_i};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Round-robin search: first synchronized requester at or after ptr, wrapping past the last port.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(PORTS)) cand = cand - (PW+1)'(PORTS);
      if (!win_vld && req_s[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Packet-locked grant FSM driving both handshakes with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant_o   <= '0;
      tail_r    <= 1'b0;
      req_dw_o  <= 1'b0;
      ack_up_o  <= '0;
      data_dw_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gidx    <= win_idx;
            grant_o <= PORTS'(1) << win_idx;
            state   <= LOAD;
          end
        end
        LOCKED: begin
          // Other ports are ignored until the owner's tail flit completes.
          if (req_s[gidx]) state <= LOAD;
        end
        LOAD: begin
          data_dw_o <= slice[gidx];
          tail_r    <= slice[gidx][TAIL_BIT];
          req_dw_o  <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          if (ack_s) begin
            req_dw_o <= 1'b0;
            ack_up_o <= grant_o;
            state    <= DONE;
          end
        end
        DONE: begin
          // Both sides must return to zero before the next flit or packet.
          if (!req_s[gidx] && !ack_s) begin
            ack_up_o <= '0;
            if (tail_r) begin
              ptr     <= (gidx == PW'(PORTS-1)) ? '0 : gidx + PW'(1);
              grant_o <= '0;
              state   <= IDLE;
            end else begin
              state   <= LOCKED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Randomized bench for switch_port_arbiter with a packet-level reference model and scoreboard.
// Upstream and downstream four-phase agents run from separate processes; a monitor checks each downstream flit.
// Every wait is cycle-bounded so the run always reaches the summary line.
module tb_switch_port_arbiter;

  localparam int WIDTH       = 128;
  localparam int PORTS       = 5;
  localparam int TAIL_BIT    = WIDTH - 1;
  localparam int SYNC_STAGES = 2;

  logic                   clk;
  logic                   rst;
  logic [PORTS-1:0]       req_up;
  logic [PORTS*WIDTH-1:0] data_up;
  logic [PORTS-1:0]       ack_up;
  logic                   req_dw;
  logic [WIDTH-1:0]       data_dw;
  logic                   ack_dw;
  logic [PORTS-1:0]       grant;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected downstream flits in service order.
  int               exp_port [$];
  logic [WIDTH-1:0] exp_data [$];
  // Flits each upstream port still has to send in the current round.
  logic [WIDTH-1:0] flit_q [PORTS][$];

  int model_ptr;
  bit mon_en;
  bit sink_en;
  bit slow_mode;

  switch_port_arbiter #(
    .WIDTH(WIDTH), .PORTS(PORTS), .TAIL_BIT(TAIL_BIT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .reset(rst),
    .req_up_i(req_up),
    .data_up_i(data_up),
    .ack_up_o(ack_up),
    .req_dw_o(req_dw),
    .data_dw_o(data_dw),
    .ack_dw_i(ack_dw),
    .grant_o(grant),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rand_flit(input bit tail);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < WIDTH/32; i++) d[i*32 +: 32] = $urandom;
    d[TAIL_BIT] = tail;
    return d;
  endfunction

  // Reference: packets are served whole; each next owner is the first pending
  // port at or after the pointer, and the pointer moves past each finished owner.
  function automatic void model_round(input logic [PORTS-1:0] mask);
    logic [PORTS-1:0] pend;
    int w;
    int p;
    pend = mask;
    while (pend != '0) begin
      w = -1;
      for (int k = 0; k < PORTS; k++) begin
        p = (model_ptr + k) % PORTS;
        if (w < 0 && pend[p]) w = p;
      end
      pend[w] = 1'b0;
      for (int i = 0; i < flit_q[w].size(); i++) begin
        exp_port.push_back(w);
        exp_data.push_back(flit_q[w][i]);
      end
      model_ptr = (w + 1) % PORTS;
    end
  endfunction

  task automatic check_zero(input string name);
    checks++;
    if (req_dw !== 1'b0 || ack_up !== '0 || data_dw !== '0 || grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: req_dw=%b ack_up=%b grant=%b busy=%b data_dw=%h, required all zero",
               name, req_dw, ack_up, grant, busy, data_dw);
    end
  endtask

  // One round: every port in mask presents one packet at the same time.
  task automatic run_round(input logic [PORTS-1:0] mask, input int minlen, input int maxlen, input bit slow);
    int  nf;
    int  len;
    int  cyc;
    bit  all_done;
    int  phase [PORTS];
    nf = 0;
    for (int p = 0; p < PORTS; p++) begin
      flit_q[p].delete();
      if (mask[p]) begin
        len = $urandom_range(minlen, maxlen);
        for (int f = 0; f < len; f++) begin
          flit_q[p].push_back(rand_flit(f == len - 1));
          nf++;
        end
      end
      phase[p] = mask[p] ? 0 : 3;
    end
    model_round(mask);
    slow_mode = slow;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 100*nf + 200) begin
      @(negedge clk);
      cyc++;
      all_done = 1'b1;
      for (int p = 0; p < PORTS; p++) begin
        case (phase[p])
          0: begin
            data_up[p*WIDTH +: WIDTH] = flit_q[p][0];
            req_up[p] = 1'b1;
            phase[p] = 1;
          end
          1: if (ack_up[p]) begin
            req_up[p] = 1'b0;
            phase[p] = 2;
          end
          2: if (!ack_up[p]) begin
            void'(flit_q[p].pop_front());
            phase[p] = (flit_q[p].size() > 0) ? 0 : 3;
          end
          default: ;
        endcase
        if (phase[p] != 3) all_done = 1'b0;
      end
    end
    checks++;
    if (!all_done) begin
      failures++;
      $display("FAIL round_timeout: mask=%b not drained after %0d cycles (required completion)", mask, cyc);
    end
    req_up = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_port.size() != 0) begin
      failures++;
      $display("FAIL round_leftover: mask=%b %0d expected flits never seen, required 0", mask, exp_port.size());
    end
    exp_port.delete();
    exp_data.delete();
    slow_mode = 1'b0;
  endtask

  // Downstream sink: four-phase acknowledge after a random or long delay.
  initial begin
    int cnt;
    int tgt;
    cnt = 0;
    tgt = 0;
    ack_dw = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !sink_en) begin
        ack_dw = 1'b0;
        cnt = 0;
      end else if (req_dw && !ack_dw) begin
        if (cnt == 0) tgt = slow_mode ? 50 : $urandom_range(0, 3);
        if (cnt >= tgt) ack_dw = 1'b1;
        else cnt++;
      end else if (!req_dw && ack_dw) begin
        ack_dw = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard compare on each new downstream flit.
  initial begin
    bit               prev;
    logic [WIDTH-1:0] held;
    int               hi_cnt;
    int               ep;
    logic [WIDTH-1:0] ed;
    logic [PORTS-1:0] eg;
    prev = 1'b0;
    held = '0;
    hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        checks++;
        if ($countones(ack_up) > 1 || (ack_up & ~grant) != '0 || $countones(grant) > 1 ||
            busy != (grant != '0) || (req_dw && ack_up != '0)) begin
          failures++;
          $display("FAIL invariant: ack_up=%b grant=%b busy=%b req_dw=%b (ack exclusive to owner, busy iff granted)",
                   ack_up, grant, busy, req_dw);
        end
        if (mon_en) begin
          if (req_dw && !prev) begin
            checks++;
            if (exp_port.size() == 0) begin
              failures++;
              $display("FAIL unexpected_flit: grant=%b data=%h, no flit expected", grant, data_dw);
            end else begin
              ep = exp_port.pop_front();
              ed = exp_data.pop_front();
              eg = PORTS'(1) << ep;
              if (grant != eg) begin
                failures++;
                $display("FAIL flit_grant: grant=%b, required %b", grant, eg);
              end
              checks++;
              if (data_dw != ed) begin
                failures++;
                $display("FAIL flit_data: data=%h, required %h", data_dw, ed);
              end
            end
            held = data_dw;
            hi_cnt = 0;
          end else if (req_dw && prev) begin
            checks++;
            if (data_dw != held) begin
              failures++;
              $display("FAIL data_stable: data=%h changed from %h while req_dw high", data_dw, held);
            end
          end
          if (req_dw) hi_cnt++;
          if (!req_dw && prev && slow_mode) begin
            checks++;
            if (hi_cnt < 50) begin
              failures++;
              $display("FAIL slow_hold: req_dw high %0d cycles, required at least 50", hi_cnt);
            end
          end
        end
        prev = req_dw;
      end
    end
  end

  // Main sequence.
  initial begin
    int w;
    logic [PORTS-1:0] mask;
    rst = 1'b1;
    req_up = '0;
    data_up = '0;
    mon_en = 1'b0;
    sink_en = 1'b0;
    slow_mode = 1'b0;
    model_ptr = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Reset while a flit is outstanding downstream (sink holds ack low).
    data_up[1*WIDTH +: WIDTH] = rand_flit(1'b0);
    req_up[1] = 1'b1;
    w = 0;
    while (!req_dw && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!req_dw) begin
      failures++;
      $display("FAIL mid_req_setup: req_dw=%b after %0d cycles, required 1", req_dw, w);
    end
    #2 rst = 1'b1;
    #1 check_zero("reset_mid_req");
    req_up = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    mon_en = 1'b1;
    sink_en = 1'b1;

    run_round(5'b01000, 1, 1, 1'b0);   // port 3 alone after reset
    run_round(5'b10001, 1, 1, 1'b0);   // pointer at 4: port 4 then wrap to port 0

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_ptr = 0;
    run_round(5'b11111, 1, 1, 1'b0);   // all ports, single flits, from reset
    run_round(5'b00100, 3, 3, 1'b0);   // 3-flit packet on port 2
    run_round(5'b00001, 1, 1, 1'b0);   // moves pointer to 1
    run_round(5'b11111, 2, 3, 1'b0);   // port 1 multi-flit locks out port 0
    run_round(5'b00100, 1, 2, 1'b1);   // slow downstream

    repeat (25) begin
      mask = PORTS'($urandom_range(1, (1 << PORTS) - 1));
      run_round(mask, 1, 4, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
